// File: rtl/enc8to3_q.sv
// rtl/enc8to3_q.sv - queued 8-to-3 request encoder; optional ENC_ROUND_ROBIN_EN selects round-robin arbitration
module enc8to3_q (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_n,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pend,
  output logic       drop,
  output logic       idle
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] req;
  logic       load;
  logic [2:0] sel;
  logic [7:0] clr;

  // Requests arrive active-low to pair with the 3-to-8 decoder outputs.
  assign req   = ~req_n;
  assign valid = (state == FULL);
  assign idle  = (pend == 8'h00) && !valid;

  // A new code is taken whenever something is pending and the output slot is free or being drained.
  assign load = (pend != 8'h00) && ((state == EMPTY) || ready);

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr;

  // Round-robin search: start just after the last served index, first pending index wins.
  always_comb begin
    sel = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (pend[3'(ptr + 3'(k))]) begin
        sel = 3'(ptr + 3'(k));
      end
    end
  end

  // Pointer follows the most recently served index; reset value 7 makes index 0 searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd7;
    end else if (load) begin
      ptr <= sel;
    end
  end
`else
  // Fixed priority: the highest pending index wins, so later (higher) hits overwrite lower ones.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) begin
        sel = 3'(i);
      end
    end
  end
`endif

  // Only the bit being served is cleared; a simultaneous new request on that bit re-sets it.
  always_comb begin
    clr = 8'h00;
    if (load) begin
      clr[sel] = 1'b1;
    end
  end

  // Pending vector, overflow flag and the EMPTY/FULL output stage with registered code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 8'h00;
      drop  <= 1'b0;
      code  <= 3'd0;
      state <= EMPTY;
    end else begin
      pend <= (pend & ~clr) | req;
      drop <= |(req & pend & ~clr);
      case (state)
        EMPTY: begin
          if (load) begin
            code  <= sel;
            state <= FULL;
          end
        end
        FULL: begin
          if (ready) begin
            if (load) begin
              code <= sel;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_enc8to3_q.sv
// tb/tb_enc8to3_q.sv - scoreboard bench for enc8to3_q (fixed priority, or round robin with ENC_ROUND_ROBIN_EN)
module tb_enc8to3_q;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       drop;
  logic       idle;

  int         tests;
  int         fails;
  int         drop_count;
  logic [2:0] exp_q[$];
  logic       hold;
  logic [2:0] held_code;

  enc8to3_q dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_n (req_n),
    .ready (ready),
    .code  (code),
    .valid (valid),
    .pend  (pend),
    .drop  (drop),
    .idle  (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_n = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expected code on each handshake and checks stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_code", 32'(code), 32'(held_code));
        check("hold_valid", 32'(valid), 32'd1);
      end
      if (drop) drop_count++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_code: got %0d expected none", code);
        end else begin
          check("code", 32'(code), 32'(exp_q.pop_front()));
        end
      end
      hold      = valid && !ready;
      held_code = code;
    end
  end

  initial begin
    tests      = 0;
    fails      = 0;
    drop_count = 0;
    hold       = 1'b0;
    held_code  = 3'd0;
    rst_n      = 1'b0;
    req_n      = 8'hFF;
    ready      = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_pend", 32'(pend), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    do_reset();

    // Single request: code 3 two edges after req_n goes low
    ready = 1'b1;
    exp_q.push_back(3'd3);
    req_n = 8'hF7;
    step(1);
    check("single_pend", 32'(pend), 32'h08);
    check("single_valid_early", 32'(valid), 32'd0);
    req_n = 8'hFF;
    step(1);
    check("single_valid", 32'(valid), 32'd1);
    check("single_code", 32'(code), 32'd3);
    step(1);
    check("single_valid_after", 32'(valid), 32'd0);
    check("single_idle", 32'(idle), 32'd1);

    // Four simultaneous requests, back-to-back delivery
    do_reset();
    ready = 1'b1;
`ifdef ENC_ROUND_ROBIN_EN
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd5); exp_q.push_back(3'd7);
`else
    exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
`endif
    req_n = 8'h5A;
    step(1);
    req_n = 8'hFF;
    step(6);
    check("multi_idle", 32'(idle), 32'd1);

    // Indices 0 and 7 together; for round robin the pointer now sits at 7
`ifdef ENC_ROUND_ROBIN_EN
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
`else
    exp_q.push_back(3'd7); exp_q.push_back(3'd0);
`endif
    req_n = 8'h7E;
    step(1);
    req_n = 8'hFF;
    step(4);
    check("pair_idle", 32'(idle), 32'd1);

    // Backpressure: code 4 held while index 6 arrives, then 6 follows
    ready = 1'b0;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd6);
    req_n = 8'hEF;
    step(1);
    req_n = 8'hFF;
    step(1);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_code", 32'(code), 32'd4);
    req_n = 8'hBF;
    step(1);
    req_n = 8'hFF;
    step(4);
    check("bp_code_held", 32'(code), 32'd4);
    check("bp_pend", 32'(pend), 32'h40);
    ready = 1'b1;
    step(4);
    check("bp_idle", 32'(idle), 32'd1);

    // Merge and drop: index 2 requested twice while output is stalled
    ready = 1'b0;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd2);
    req_n = 8'hEF;
    step(1);
    req_n = 8'hFF;
    step(1);
    drop_count = 0;
    req_n = 8'hFB;
    step(2);
    req_n = 8'hFF;
    step(2);
    check("merge_pend", 32'(pend), 32'h04);
    check("merge_drop_count", 32'(drop_count), 32'd1);
    ready = 1'b1;
    step(4);
    check("merge_idle", 32'(idle), 32'd1);

    // Reset mid-operation with everything pending
    ready = 1'b0;
    req_n = 8'h00;
    step(2);
    req_n = 8'hFF;
    check("pre_rst_pend", 32'(pend), 32'hFF);
    check("pre_rst_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pend", 32'(pend), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_code", 32'(code), 32'd0);
    check("mid_rst_drop", 32'(drop), 32'd0);
    req_n = 8'h00;
    step(1);
    check("rst_ignores_req", 32'(pend), 32'h00);
    req_n = 8'hFF;
    rst_n = 1'b1;
    ready = 1'b1;
    step(5);
    check("post_rst_valid", 32'(valid), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
